// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the two writeback sources, the read-address taps and the reg_file write port.
// The slave modport is the arbiter side; master is the sources/reg_file side.
interface reg_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              REQ_A;
  logic [ADDR_W-1:0] WREG_A;
  logic [DATA_W-1:0] WDATA_A;
  logic              ACK_A;
  logic              REQ_B;
  logic [ADDR_W-1:0] WREG_B;
  logic [DATA_W-1:0] WDATA_B;
  logic              ACK_B;
  logic [ADDR_W-1:0] READREG1;
  logic [ADDR_W-1:0] READREG2;
  logic [ADDR_W-1:0] WRITEREG;
  logic [DATA_W-1:0] WRITEDATA;
  logic              WRITEENABLE;
  logic              HAZARD;
  logic              BUSY;

  modport master (
    output REQ_A, WREG_A, WDATA_A, REQ_B, WREG_B, WDATA_B, READREG1, READREG2,
    input  ACK_A, ACK_B, WRITEREG, WRITEDATA, WRITEENABLE, HAZARD, BUSY
  );

  modport slave (
    input  REQ_A, WREG_A, WDATA_A, REQ_B, WREG_B, WDATA_B, READREG1, READREG2,
    output ACK_A, ACK_B, WRITEREG, WRITEDATA, WRITEENABLE, HAZARD, BUSY
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single reg_file write port between requester A (ALU) and B (load return).
// Default is round-robin; define ARB_FIXED_PRIO_EN to make A always win contention.
module reg_write_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  reg_write_arbiter_if.slave bus
);
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  last_e             r_last;
  last_e             w_last_nxt;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_writereg;
  logic [DATA_W-1:0] r_writedata;

  logic              w_ack_a_nxt;
  logic              w_ack_b_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_writereg_nxt;
  logic [DATA_W-1:0] w_writedata_nxt;
  logic              w_eff_a;
  logic              w_eff_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_hazard;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last      <= LAST_B;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_we        <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
    end else begin
      r_last      <= w_last_nxt;
      r_ack_a     <= w_ack_a_nxt;
      r_ack_b     <= w_ack_b_nxt;
      r_we        <= w_we_nxt;
      r_writereg  <= w_writereg_nxt;
      r_writedata <= w_writedata_nxt;
    end
  end

  // Grant decision; a requester's REQ is ignored during its own ack cycle
  always_comb begin
    w_last_nxt      = r_last;
    w_ack_a_nxt     = 1'b0;
    w_ack_b_nxt     = 1'b0;
    w_we_nxt        = 1'b0;
    w_writereg_nxt  = r_writereg;
    w_writedata_nxt = r_writedata;

    w_eff_a = bus.REQ_A & ~r_ack_a;
    w_eff_b = bus.REQ_B & ~r_ack_b;
`ifdef ARB_FIXED_PRIO_EN
    w_grant_a = w_eff_a;
`else
    w_grant_a = w_eff_a & (~w_eff_b | (r_last == LAST_B));
`endif
    w_grant_b = w_eff_b & ~w_grant_a;

    if (w_grant_a) begin
      w_last_nxt      = LAST_A;
      w_ack_a_nxt     = 1'b1;
      w_we_nxt        = 1'b1;
      w_writereg_nxt  = bus.WREG_A;
      w_writedata_nxt = bus.WDATA_A;
    end else if (w_grant_b) begin
      w_last_nxt      = LAST_B;
      w_ack_b_nxt     = 1'b1;
      w_we_nxt        = 1'b1;
      w_writereg_nxt  = bus.WREG_B;
      w_writedata_nxt = bus.WDATA_B;
    end

    w_hazard = (w_eff_a & ((bus.WREG_A == bus.READREG1) | (bus.WREG_A == bus.READREG2)))
             | (w_eff_b & ((bus.WREG_B == bus.READREG1) | (bus.WREG_B == bus.READREG2)))
             | (r_we    & ((r_writereg == bus.READREG1) | (r_writereg == bus.READREG2)));
  end

  assign bus.ACK_A       = r_ack_a;
  assign bus.ACK_B       = r_ack_b;
  assign bus.WRITEENABLE = r_we;
  assign bus.WRITEREG    = r_writereg;
  assign bus.WRITEDATA   = r_writedata;
  assign bus.BUSY        = w_eff_a & w_eff_b;
  assign bus.HAZARD      = w_hazard;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed vector table followed by random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_reg_write_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_errors;

  reg_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst;
    bit       ra;
    bit [2:0] wa;
    bit [7:0] da;
    bit       rb;
    bit [2:0] wb;
    bit [7:0] db;
    bit [2:0] r1;
    bit [2:0] r2;
    bit       e_busy;
    bit       e_haz;
    bit       e_acka;
    bit       e_ackb;
    bit       e_we;
    bit [2:0] e_wreg;
    bit [7:0] e_wdata;
  } vec_t;

  vec_t tbl[$];

  // Model state: outputs the arbiter should present after the latest edge
  bit       m_acka, m_ackb, m_we;
  bit [2:0] m_wreg;
  bit [7:0] m_wdata;
  int       m_last;  // 0 = A won last, 1 = B won last

  function automatic vec_t mk(int rst, int ra, int wa, int da, int rb, int wb, int db,
                              int r1, int r2, int busy, int haz, int acka, int ackb,
                              int we, int wreg, int wdata);
    vec_t v;
    v.rst = 1'(rst);  v.ra = 1'(ra);  v.wa = 3'(wa);  v.da = 8'(da);
    v.rb = 1'(rb);    v.wb = 3'(wb);  v.db = 8'(db);
    v.r1 = 3'(r1);    v.r2 = 3'(r2);
    v.e_busy = 1'(busy); v.e_haz = 1'(haz);
    v.e_acka = 1'(acka); v.e_ackb = 1'(ackb); v.e_we = 1'(we);
    v.e_wreg = 3'(wreg); v.e_wdata = 8'(wdata);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag, input bit acka, input bit ackb, input bit we,
                            input bit [2:0] wreg, input bit [7:0] wdata);
    chk({tag, " ACK_A"},       32'(bus.ACK_A),       32'(acka));
    chk({tag, " ACK_B"},       32'(bus.ACK_B),       32'(ackb));
    chk({tag, " WRITEENABLE"}, 32'(bus.WRITEENABLE), 32'(we));
    chk({tag, " WRITEREG"},    32'(bus.WRITEREG),    32'(wreg));
    chk({tag, " WRITEDATA"},   32'(bus.WRITEDATA),   32'(wdata));
  endtask

  // Applies the arbitration rules to the inputs present at this edge
  task automatic model_edge();
    bit ea, eb;
    int win;
    if (RESET) begin
      m_acka = 0; m_ackb = 0; m_we = 0; m_wreg = 0; m_wdata = 0; m_last = 1;
      return;
    end
    ea  = bus.REQ_A && !m_acka;
    eb  = bus.REQ_B && !m_ackb;
    win = -1;
    if (ea && eb) win = FIXED ? 0 : 1 - m_last;
    else if (ea)  win = 0;
    else if (eb)  win = 1;
    m_acka = (win == 0);
    m_ackb = (win == 1);
    m_we   = (win >= 0);
    if (win == 0) begin m_wreg = bus.WREG_A; m_wdata = bus.WDATA_A; end
    if (win == 1) begin m_wreg = bus.WREG_B; m_wdata = bus.WDATA_B; end
    if (win >= 0) m_last = win;
  endtask

  // Pending or in-flight destination registers, compared against the read addresses
  task automatic check_comb(input string tag);
    bit [2:0] dests[$];
    bit ea, eb, haz;
    ea = bus.REQ_A && !m_acka;
    eb = bus.REQ_B && !m_ackb;
    if (ea)   dests.push_back(bus.WREG_A);
    if (eb)   dests.push_back(bus.WREG_B);
    if (m_we) dests.push_back(m_wreg);
    haz = 0;
    foreach (dests[i]) if (dests[i] == bus.READREG1 || dests[i] == bus.READREG2) haz = 1;
    chk({tag, " BUSY"},   32'(bus.BUSY),   32'(ea && eb));
    chk({tag, " HAZARD"}, 32'(bus.HAZARD), 32'(haz));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET = 1'b1;
    bus.REQ_A = 0; bus.WREG_A = 0; bus.WDATA_A = 0;
    bus.REQ_B = 0; bus.WREG_B = 0; bus.WDATA_B = 0;
    bus.READREG1 = 3'd1; bus.READREG2 = 3'd2;

    // Directed vectors: inputs for one cycle, pre-edge BUSY/HAZARD, post-edge registered outputs
    tbl.push_back(mk(0,1,2,95,0,0,0,7,7, 0,0, 1,0,1,2,95));
    tbl.push_back(mk(0,1,2,95,0,0,0,2,7, 0,1, 0,0,0,2,95));
    tbl.push_back(mk(0,0,0,0,0,0,0,2,7,  0,0, 0,0,0,2,95));
    tbl.push_back(mk(1,1,5,9,0,0,0,5,0,  0,1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,5,9,0,0,0,5,0,  0,1, 1,0,1,5,9));
    tbl.push_back(mk(0,0,0,0,0,0,0,3,3,  0,0, 0,0,0,5,9));
    tbl.push_back(mk(1,1,1,28,1,4,6,0,0, 1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,28,1,4,6,0,0, 1,0, 1,0,1,1,28));
    tbl.push_back(mk(0,1,1,28,1,4,6,0,0, 0,0, 0,1,1,4,6));
    tbl.push_back(mk(0,0,0,0,1,4,6,0,0,  0,0, 0,0,0,4,6));
    tbl.push_back(mk(0,1,6,3,0,0,0,0,0,  0,0, 1,0,1,6,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,  0,0, 0,0,0,6,3));
    tbl.push_back(mk(0,1,4,15,1,7,50,4,0, 1,1, FIXED ? 1 : 0, FIXED ? 0 : 1, 1,
                     FIXED ? 4 : 7, FIXED ? 15 : 50));
    tbl.push_back(mk(0,1,4,15,1,7,50,4,0, 0,1, FIXED ? 0 : 1, FIXED ? 1 : 0, 1,
                     FIXED ? 7 : 4, FIXED ? 50 : 15));
    tbl.push_back(mk(0,0,0,0,0,0,0,4,0, 0, FIXED ? 0 : 1, 0,0,0,
                     FIXED ? 7 : 4, FIXED ? 50 : 15));
    tbl.push_back(mk(0,0,0,0,1,4,77,4,0, 0,1, 0,1,1,4,77));
    tbl.push_back(mk(0,0,0,0,0,0,0,4,0,  0,1, 0,0,0,4,77));
    tbl.push_back(mk(0,0,0,0,0,0,0,4,0,  0,0, 0,0,0,4,77));
    tbl.push_back(mk(0,0,0,0,1,4,1,3,3,  0,0, 0,1,1,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,3,4,  0,1, 0,0,0,4,1));

    // Two reset cycles with no requests
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check_regs("reset", 0, 0, 0, 3'd0, 8'd0);
    chk("reset BUSY",   32'(bus.BUSY),   32'd0);
    chk("reset HAZARD", 32'(bus.HAZARD), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      RESET        = tbl[i].rst;
      bus.REQ_A    = tbl[i].ra; bus.WREG_A = tbl[i].wa; bus.WDATA_A = tbl[i].da;
      bus.REQ_B    = tbl[i].rb; bus.WREG_B = tbl[i].wb; bus.WDATA_B = tbl[i].db;
      bus.READREG1 = tbl[i].r1; bus.READREG2 = tbl[i].r2;
      #1;
      chk({tag, " BUSY"},   32'(bus.BUSY),   32'(tbl[i].e_busy));
      chk({tag, " HAZARD"}, 32'(bus.HAZARD), 32'(tbl[i].e_haz));
      @(posedge CLK);
      @(negedge CLK);
      check_regs(tag, tbl[i].e_acka, tbl[i].e_ackb, tbl[i].e_we, tbl[i].e_wreg, tbl[i].e_wdata);
    end

    // Random traffic against the model, starting from a fresh reset
    RESET = 1'b1;
    bus.REQ_A = 0; bus.REQ_B = 0;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_regs("rnd reset", m_acka, m_ackb, m_we, m_wreg, m_wdata);

    for (int c = 0; c < 400; c++) begin
      string tag;
      tag = $sformatf("rnd%0d", c);
      RESET = ($urandom_range(0, 24) == 0);
      if (bus.REQ_A && m_acka) begin
        bus.REQ_A = ($urandom_range(0, 2) == 0);
        bus.WREG_A = 3'($urandom_range(0, 7)); bus.WDATA_A = 8'($urandom);
      end else if (bus.REQ_A) begin
        if ($urandom_range(0, 9) == 0) bus.REQ_A = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        bus.REQ_A = 1'b1;
        bus.WREG_A = 3'($urandom_range(0, 7)); bus.WDATA_A = 8'($urandom);
      end
      if (bus.REQ_B && m_ackb) begin
        bus.REQ_B = ($urandom_range(0, 2) == 0);
        bus.WREG_B = 3'($urandom_range(0, 7)); bus.WDATA_B = 8'($urandom);
      end else if (bus.REQ_B) begin
        if ($urandom_range(0, 9) == 0) bus.REQ_B = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        bus.REQ_B = 1'b1;
        bus.WREG_B = 3'($urandom_range(0, 7)); bus.WDATA_B = 8'($urandom);
      end
      bus.READREG1 = 3'($urandom_range(0, 7));
      bus.READREG2 = 3'($urandom_range(0, 7));
      #1;
      check_comb(tag);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_regs(tag, m_acka, m_ackb, m_we, m_wreg, m_wdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port (WRITEREG/WRITEDATA/WRITEENABLE) between two writeback sources.
  - Requester A: ALU result path.
  - Requester B: memory-load return path.
- Sits between the writeback sources and reg_file.
- Handles arbitration, a per-requester req/ack handshake, and a read-after-write hazard flag that the control unit uses for stalling.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 3, register address width (2**ADDR_W registers).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ_A  input  1  requester A wants a write; held until acked.
- WREG_A  input  ADDR_W  destination register for A.
- WDATA_A  input  DATA_W  write data for A.
- ACK_A  output  1  one-cycle grant pulse to A.
- REQ_B  input  1  requester B wants a write; held until acked.
- WREG_B  input  ADDR_W  destination register for B.
- WDATA_B  input  DATA_W  write data for B.
- ACK_B  output  1  one-cycle grant pulse to B.
- READREG1  input  ADDR_W  read address 1 currently presented to reg_file.
- READREG2  input  ADDR_W  read address 2 currently presented to reg_file.
- WRITEREG  output  ADDR_W  to reg_file write address.
- WRITEDATA  output  DATA_W  to reg_file write data.
- WRITEENABLE  output  1  to reg_file write enable.
- HAZARD  output  1  a pending or in-flight write targets READREG1 or READREG2.
- BUSY  output  1  both requesters contending this cycle (one must wait).

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RESET), sampled on rising CLK edge.
- Reset values:
  - WRITEREG=0, WRITEDATA=0, WRITEENABLE=0, ACK_A=0, ACK_B=0.
  - Round-robin pointer LAST=B, so A wins the first contention.
- Reset wins over everything at that edge.
  - Any grant decided in the same cycle is discarded; no ack is issued.
  - Requesters still holding REQ are re-arbitrated after RESET falls.
- Effective requests each edge:
  - effA = REQ_A & ~ACK_A; effB = REQ_B & ~ACK_B.
  - REQ is ignored on the edge where its own ACK is high, so a requester still holding REQ during its ack cycle is never double-granted.
- Grant decision at edge N:
  - Only effA: grant A.
  - Only effB: grant B.
  - Both: grant the requester that is not LAST.
  - Neither: no grant.
- Grant effect, registered and visible during cycle N+1:
  - WRITEREG/WRITEDATA = winner's WREG/WDATA; WRITEENABLE=1; winner's ACK=1; LAST=winner.
- No grant: WRITEENABLE=0, both ACKs=0. WRITEREG/WRITEDATA hold their previous values.
- Latency: REQ sampled at edge N produces ACK and WRITEENABLE in cycle N+1. reg_file commits at edge N+1.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed when the other is idle.
  - The re-grant happens no earlier than two edges after the first, because of the ack-cycle ignore rule.
- Requester rules: REQ, WREG and WDATA stay stable from assertion until the edge where ACK is sampled high. Dropping REQ before ack withdraws the request with no write.
- Same destination register from both requesters: no special handling. Writes commit in grant order; the later grant wins.
- BUSY (combinational) = effA & effB.
- HAZARD (combinational) = 1 if any of the following match READREG1 or READREG2:
  - WREG_A when effA;
  - WREG_B when effB;
  - WRITEREG when WRITEENABLE=1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins contention; LAST is still updated but unused; B can starve while A requests continuously.
- Not defined: round-robin as described in Behaviour.

Test Plan:
- RESET=1 for 2 cycles, REQ_A=REQ_B=0 -> all outputs 0 after first edge; HAZARD=0; BUSY=0.
- REQ_A=1, WREG_A=2, WDATA_A=95, held until ack -> next cycle ACK_A=1, WRITEENABLE=1, WRITEREG=2, WRITEDATA=95; following cycle WRITEENABLE=0; reg2 reads 95.
- REQ_A and REQ_B both asserted from reset release (A: reg1=28, B: reg4=6), held until each is acked -> BUSY=1 at the first edge; A acked first, B acked next cycle; reg1=28, reg4=6.
  - Repeat with A: reg4=15 and B: reg7=50 -> B granted first (LAST=A); with ARB_FIXED_PRIO_EN defined, A granted first.
- REQ_B held high through its ACK cycle, REQ_A=0 -> exactly one write; no second ACK_B on the edge where ACK_B is high.
- READREG1=4 while REQ_B pending with WREG_B=4 -> HAZARD=1 until the cycle after WRITEENABLE deasserts; READREG1=3 instead -> HAZARD=0.
- RESET asserted on the same edge as a grant decision for REQ_A (reg5=9) -> no ACK_A, WRITEENABLE stays 0; after RESET falls, A is granted on the first edge.
